// File: rtl/riscm_ctrl_pkg.sv
// Shared types and encodings for the RISC machine control unit:
// FSM states, opcode/ALUop/vsel encodings and the decoded instruction class.
package riscm_ctrl_pkg;

    typedef enum logic [2:0] {
        WAIT      = 3'd0,
        DECODE    = 3'd1,
        WRITE_IMM = 3'd2,
        GET_A     = 3'd3,
        GET_B     = 3'd4,
        ALU       = 3'd5,
        WRITE_REG = 3'd6
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // op field values that select the MOV variant under OPC_MOV
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    localparam logic [1:0] VSEL_MDATA = 2'b00;
    localparam logic [1:0] VSEL_IMM8  = 2'b01;
    localparam logic [1:0] VSEL_PC    = 2'b10;  // reserved for branch-and-link
    localparam logic [1:0] VSEL_C     = 2'b11;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_MOV_IMM = 3'd1,
        CLS_MOV_REG = 3'd2,
        CLS_ADD     = 3'd3,
        CLS_CMP     = 3'd4,
        CLS_AND     = 3'd5,
        CLS_MVN     = 3'd6
    } instr_cls_t;

endpackage

// File: rtl/riscm_instr_dec.sv
// Combinational instruction decoder: splits the IR into register/shift fields,
// sign-extends the immediates and classifies the encoding (including illegal).
module riscm_instr_dec
    import riscm_ctrl_pkg::*;
(
    input  logic [15:0] i_ir,
    output logic [2:0]  o_rn,
    output logic [2:0]  o_rd,
    output logic [2:0]  o_rm,
    output logic [1:0]  o_sh,
    output logic [1:0]  o_op,
    output logic [15:0] o_sximm5,
    output logic [15:0] o_sximm8,
    output instr_cls_t  o_cls
);

    logic [2:0] w_opcode;

    assign w_opcode = i_ir[15:13];
    assign o_op     = i_ir[12:11];
    assign o_rn     = i_ir[10:8];
    assign o_rd     = i_ir[7:5];
    assign o_sh     = i_ir[4:3];
    assign o_rm     = i_ir[2:0];

    assign o_sximm5 = {{11{i_ir[4]}}, i_ir[4:0]};
    assign o_sximm8 = {{8{i_ir[7]}}, i_ir[7:0]};

    always_comb begin
        o_cls = CLS_ILLEGAL;
        case (w_opcode)
            OPC_MOV: begin
                if (o_op == OP_MOV_IMM) begin
                    o_cls = CLS_MOV_IMM;
                end else if (o_op == OP_MOV_REG) begin
                    o_cls = CLS_MOV_REG;
                end
            end
            OPC_ALU: begin
                case (o_op)
                    ALU_ADD: o_cls = CLS_ADD;
                    ALU_CMP: o_cls = CLS_CMP;
                    ALU_AND: o_cls = CLS_AND;
                    default: o_cls = CLS_MVN;
                endcase
            end
            default: o_cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/riscm_ctrl.sv
// RISC machine control unit: instruction register, decoder and the multi-cycle
// Moore FSM that sequences register reads, ALU, status load and write-back.
module riscm_ctrl
    import riscm_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic        err,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [2:0]  readnum,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic [1:0]  vsel,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8,
    output state_t      o_dbg_state
);

    state_t     r_state;
    state_t     w_next;
    logic [15:0] r_ir;
    logic        r_err;

    logic [2:0]  w_rn;
    logic [2:0]  w_rd;
    logic [2:0]  w_rm;
    logic [1:0]  w_sh;
    logic [1:0]  w_op;
    instr_cls_t  w_cls;

    riscm_instr_dec u_dec (
        .i_ir     (r_ir),
        .o_rn     (w_rn),
        .o_rd     (w_rd),
        .o_rm     (w_rm),
        .o_sh     (w_sh),
        .o_op     (w_op),
        .o_sximm5 (sximm5),
        .o_sximm8 (sximm8),
        .o_cls    (w_cls)
    );

    // IR only loads while idle so an in-flight instruction never changes under the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= WAIT;
            r_ir    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == WAIT && load) begin
                r_ir <= in;
            end
            if (r_state == DECODE) begin
                r_err <= (w_cls == CLS_ILLEGAL);
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        w        = 1'b0;
        writenum = 3'd0;
        write    = 1'b0;
        readnum  = 3'd0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        vsel     = VSEL_MDATA;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = ALU_ADD;

        case (r_state)
            WAIT: begin
                w = 1'b1;
                if (s) begin
                    w_next = DECODE;
                end
            end
            DECODE: begin
                case (w_cls)
                    CLS_MOV_IMM:                w_next = WRITE_IMM;
                    CLS_MOV_REG, CLS_MVN:       w_next = GET_B;
                    CLS_ADD, CLS_CMP, CLS_AND:  w_next = GET_A;
                    default:                    w_next = WAIT;
                endcase
            end
            WRITE_IMM: begin
                writenum = w_rn;
                vsel     = VSEL_IMM8;
                write    = 1'b1;
                w_next   = WAIT;
            end
            GET_A: begin
                readnum = w_rn;
                loada   = 1'b1;
                w_next  = GET_B;
            end
            GET_B: begin
                readnum = w_rm;
                loadb   = 1'b1;
                w_next  = ALU;
            end
            ALU: begin
                shift = w_sh;
                // MOV reg runs through the ALU as 0 + B with the A input forced to zero
                if (w_cls == CLS_MOV_REG) begin
                    asel  = 1'b1;
                    ALUop = ALU_ADD;
                end else begin
                    ALUop = w_op;
                end
                if (w_cls == CLS_CMP) begin
                    loads  = 1'b1;
                    w_next = WAIT;
                end else begin
                    loadc  = 1'b1;
                    w_next = WRITE_REG;
                end
            end
            WRITE_REG: begin
                writenum = w_rd;
                vsel     = VSEL_C;
                write    = 1'b1;
                w_next   = WAIT;
            end
            default: w_next = WAIT;
        endcase
    end

    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_riscm_ctrl.sv
// Directed bench for riscm_ctrl: expected per-cycle control words are queued at
// issue time and compared by an independent negedge monitor.
module tb_riscm_ctrl;
    import riscm_ctrl_pkg::*;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] in_w    = 16'h0000;
    logic        load    = 1'b0;
    logic        s       = 1'b0;

    logic        w, err, write, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  writenum, readnum;
    logic [1:0]  vsel, shift, ALUop;
    logic [15:0] sximm5, sximm8;
    state_t      dbg_state;

    riscm_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in          (in_w),
        .load        (load),
        .s           (s),
        .w           (w),
        .err         (err),
        .writenum    (writenum),
        .write       (write),
        .readnum     (readnum),
        .loada       (loada),
        .loadb       (loadb),
        .loadc       (loadc),
        .loads       (loads),
        .vsel        (vsel),
        .asel        (asel),
        .bsel        (bsel),
        .shift       (shift),
        .ALUop       (ALUop),
        .sximm5      (sximm5),
        .sximm8      (sximm8),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    logic [52:0] act;
    assign act = {w, err, writenum, write, readnum, loada, loadb, loadc, loads,
                  vsel, asel, bsel, shift, ALUop, sximm5, sximm8};

    logic [52:0] exp_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] cur_sx5 = 16'h0000;
    logic [15:0] cur_sx8 = 16'h0000;
    logic [52:0] mon_e;
    string       mon_t;

    // Control word: {w, err, writenum, write, readnum, {loada,loadb,loadc,loads}, vsel, asel, bsel, shift, ALUop}
    function automatic logic [20:0] cw(input logic w_, input logic e_, input logic [2:0] wn,
                                       input logic wr, input logic [2:0] rn, input logic [3:0] en,
                                       input logic [1:0] vs, input logic as_, input logic bs_,
                                       input logic [1:0] sh, input logic [1:0] op);
        return {w_, e_, wn, wr, rn, en, vs, as_, bs_, sh, op};
    endfunction

    function automatic logic [20:0] st_idle(input logic e_);
        return cw(1'b1, e_, 3'd0, 1'b0, 3'd0, 4'b0000, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
    endfunction
    function automatic logic [20:0] st_dec(input logic e_);
        return cw(1'b0, e_, 3'd0, 1'b0, 3'd0, 4'b0000, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
    endfunction
    function automatic logic [20:0] st_wimm(input logic [2:0] rn);
        return cw(1'b0, 1'b0, rn, 1'b1, 3'd0, 4'b0000, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00);
    endfunction
    function automatic logic [20:0] st_geta(input logic [2:0] rn);
        return cw(1'b0, 1'b0, 3'd0, 1'b0, rn, 4'b1000, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
    endfunction
    function automatic logic [20:0] st_getb(input logic [2:0] rm);
        return cw(1'b0, 1'b0, 3'd0, 1'b0, rm, 4'b0100, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
    endfunction
    function automatic logic [20:0] st_alu(input logic as_, input logic [1:0] sh,
                                           input logic [1:0] op, input logic [3:0] en);
        return cw(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, en, 2'b00, as_, 1'b0, sh, op);
    endfunction
    function automatic logic [20:0] st_wreg(input logic [2:0] rd);
        return cw(1'b0, 1'b0, rd, 1'b1, 3'd0, 4'b0000, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00);
    endfunction

    task automatic ex(input logic [20:0] c, input string t);
        exp_q.push_back({c, cur_sx5, cur_sx8});
        tag_q.push_back(t);
    endtask

    task automatic check_now(input string t, input logic [52:0] e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", t, act, e);
        end
    endtask

    // load and s together in WAIT: the sampling edge latches IR and enters DECODE
    task automatic start(input logic [15:0] instr);
        @(posedge clk); #1;
        in_w = instr; load = 1'b1; s = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; s = 1'b0;
    endtask

    task automatic drain(input string t);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout with %0d expected cycles pending, required 0", t, exp_q.size());
            exp_q.delete();
            tag_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            checks++;
            if (act !== mon_e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", mon_t, act, mon_e);
            end
        end
    end

    initial begin
        #1 reset_n = 1'b0;
        #1 check_now("reset_pre_clk", {st_idle(1'b0), 16'h0000, 16'h0000});
        #10 check_now("reset_held", {st_idle(1'b0), 16'h0000, 16'h0000});
        reset_n = 1'b1;

        // MOV R0,#7
        start(16'hD007);
        cur_sx5 = 16'h0007; cur_sx8 = 16'h0007;
        ex(st_dec(1'b0), "mov7_decode");
        ex(st_wimm(3'd0), "mov7_write_imm");
        ex(st_idle(1'b0), "mov7_done");
        drain("mov7");

        // MOV R1,#-2
        start(16'hD1FE);
        cur_sx5 = 16'hFFFE; cur_sx8 = 16'hFFFE;
        ex(st_dec(1'b0), "movm2_decode");
        ex(st_wimm(3'd1), "movm2_write_imm");
        ex(st_idle(1'b0), "movm2_done");
        drain("movm2");

        // ADD R2,R1,R0,LSL#1
        start(16'hA148);
        cur_sx5 = 16'h0008; cur_sx8 = 16'h0048;
        ex(st_dec(1'b0), "add_decode");
        ex(st_geta(3'd1), "add_get_a");
        ex(st_getb(3'd0), "add_get_b");
        ex(st_alu(1'b0, 2'b01, 2'b00, 4'b0010), "add_alu");
        ex(st_wreg(3'd2), "add_write_reg");
        ex(st_idle(1'b0), "add_done");
        drain("add");

        // CMP R1,R0
        start(16'hA900);
        cur_sx5 = 16'h0000; cur_sx8 = 16'h0000;
        ex(st_dec(1'b0), "cmp_decode");
        ex(st_geta(3'd1), "cmp_get_a");
        ex(st_getb(3'd0), "cmp_get_b");
        ex(st_alu(1'b0, 2'b00, 2'b01, 4'b0001), "cmp_alu");
        ex(st_idle(1'b0), "cmp_done");
        drain("cmp");

        // MVN R3,R0 with a load/s pulse mid-instruction that must be ignored
        start(16'hB860);
        cur_sx5 = 16'h0000; cur_sx8 = 16'h0060;
        ex(st_dec(1'b0), "mvn_decode");
        ex(st_getb(3'd0), "mvn_get_b");
        ex(st_alu(1'b0, 2'b00, 2'b11, 4'b0010), "mvn_alu");
        ex(st_wreg(3'd3), "mvn_write_reg");
        ex(st_idle(1'b0), "mvn_done");
        @(posedge clk); #1;
        in_w = 16'hFFFF; load = 1'b1; s = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; s = 1'b0;
        drain("mvn");

        // MOV R2,R1,LSR-style sh=10
        start(16'hC051);
        cur_sx5 = 16'hFFF1; cur_sx8 = 16'h0051;
        ex(st_dec(1'b0), "movr_decode");
        ex(st_getb(3'd1), "movr_get_b");
        ex(st_alu(1'b1, 2'b10, 2'b00, 4'b0010), "movr_alu");
        ex(st_wreg(3'd2), "movr_write_reg");
        ex(st_idle(1'b0), "movr_done");
        drain("movr");

        // AND R7,R2,R3,sh=10
        start(16'hB2F3);
        cur_sx5 = 16'hFFF3; cur_sx8 = 16'hFFF3;
        ex(st_dec(1'b0), "and_decode");
        ex(st_geta(3'd2), "and_get_a");
        ex(st_getb(3'd3), "and_get_b");
        ex(st_alu(1'b0, 2'b10, 2'b10, 4'b0010), "and_alu");
        ex(st_wreg(3'd7), "and_write_reg");
        ex(st_idle(1'b0), "and_done");
        drain("and");

        // Illegal opcode 111, then illegal MOV op 11, then a legal MOV clears err
        start(16'hE000);
        cur_sx5 = 16'h0000; cur_sx8 = 16'h0000;
        ex(st_dec(1'b0), "ill1_decode");
        ex(st_idle(1'b1), "ill1_done");
        drain("ill1");

        start(16'hD800);
        ex(st_dec(1'b1), "ill2_decode");
        ex(st_idle(1'b1), "ill2_done");
        drain("ill2");

        start(16'hD007);
        cur_sx5 = 16'h0007; cur_sx8 = 16'h0007;
        ex(st_dec(1'b1), "clr_decode");
        ex(st_wimm(3'd0), "clr_write_imm");
        ex(st_idle(1'b0), "clr_done");
        drain("clr");

        // Asynchronous reset during GET_B of an ADD
        start(16'hA148);
        cur_sx5 = 16'h0008; cur_sx8 = 16'h0048;
        ex(st_dec(1'b0), "rst_add_decode");
        ex(st_geta(3'd1), "rst_add_get_a");
        ex(st_getb(3'd0), "rst_add_get_b");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_now("reset_async_abort", {st_idle(1'b0), 16'h0000, 16'h0000});
        #1 reset_n = 1'b1;
        cur_sx5 = 16'h0000; cur_sx8 = 16'h0000;
        ex(st_idle(1'b0), "post_reset_idle0");
        ex(st_idle(1'b0), "post_reset_idle1");
        ex(st_idle(1'b0), "post_reset_idle2");
        drain("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscm_ctrl.md
Name: riscm_ctrl

Overview:
- Control unit that drives the RISC machine datapath: instruction register, decoder and multi-cycle Moore FSM.
- Latches a 16-bit instruction, then sequences register-file reads, ALU operation, status load and register write-back using the datapath's control inputs.
- Sits between the instruction source (switches or future memory/fetch unit) and the datapath.

Parameters:
- None. Widths are fixed by the ISA: 16-bit instruction, 8 registers, 2-bit ALUop.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in  input  16  instruction word.
- load  input  1  IR load enable.
- s  input  1  start execution of the instruction held in IR.
- w  output  1  idle; 1 only in state WAIT.
- err  output  1  sticky flag set by an illegal instruction.
- writenum  output  3  register-file write address.
- write  output  1  register-file write enable.
- readnum  output  3  register-file read address.
- loada, loadb, loadc, loads  output  1 each  datapath register enables.
- vsel  output  2  write-back source: 00 mdata, 01 sximm8, 10 PC, 11 C.
- asel, bsel  output  1 each  A mux select (1 gives zero); B mux select (1 gives sximm5).
- shift  output  2  shifter control.
- ALUop  output  2  ALU operation.
- sximm5  output  16  IR[4:0], sign-extended.
- sximm8  output  16  IR[7:0], sign-extended.

Behaviour:
- IR fields:
  - [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm.
  - Legal encodings: 110/10 MOV Rn,#imm8; 110/00 MOV Rd,Rm{,sh}; 101/00 ADD; 101/01 CMP; 101/10 AND; 101/11 MVN. All others are illegal.
- Reset (asynchronous, active-low):
  - State = WAIT, IR = 0, err = 0.
  - All enables 0, readnum = writenum = 0, vsel = 00, asel = bsel = 0, shift = 00, ALUop = 00, w = 1.
  - Reset mid-instruction aborts immediately; no write occurs.
- IR load: IR <= in on the rising edge when load=1 and state=WAIT. load is ignored in every other state.
- Outputs are Moore (state + IR). Every enable and select not listed for a state is 0. sximm5 and sximm8 are continuous from IR.
- State transitions and outputs:
  - WAIT: w=1. s=1 goes to DECODE. load and s asserted together: IR takes the new word and DECODE uses it.
  - DECODE: clears err.
    - MOV imm goes to WRITE_IMM.
    - MOV reg and MVN go to GET_B.
    - ADD, CMP and AND go to GET_A.
    - Illegal sets err=1 and returns to WAIT.
  - WRITE_IMM: writenum=Rn, vsel=01, write=1. Next state WAIT.
  - GET_A: readnum=Rn, loada=1. Next state GET_B.
  - GET_B: readnum=Rm, loadb=1. Next state ALU.
  - ALU:
    - shift=sh, bsel=0.
    - asel=1 for MOV reg; otherwise asel=0 (asel is a don't-care for MVN; drive 0).
    - ALUop: MOV reg uses 00 (0+B); other instructions use op.
    - CMP: loads=1, loadc=0, next state WAIT.
    - Others: loadc=1, next state WRITE_REG.
  - WRITE_REG: writenum=Rd, vsel=11, write=1. Next state WAIT.
- Latency from the edge that samples s=1 to w=1:
  - MOV imm: 3 cycles.
  - MOV reg, MVN, CMP: 4 cycles.
  - ADD, AND: 5 cycles.
  - Illegal: 2 cycles.
- s held high in WAIT starts back-to-back instructions. s is ignored outside WAIT.
- vsel=10 (PC) is never driven by the current ISA; the encoding is reserved for branch-and-link.

Decomposition:
- Package riscm_ctrl_pkg holds:
  - state enum: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG.
  - opcode constants OPC_MOV=3'b110, OPC_ALU=3'b101.
  - ALUop constants ADD=00, CMP=01, AND=10, MVN=11.
  - VSEL_* constants.
- One sub-module, riscm_instr_dec (combinational), maps IR to the fields, sximm5/sximm8 and an instruction-class/illegal indicator. The FSM lives in riscm_ctrl.

Test Plan:
- Load 0xD007 (MOV R0,#7) and pulse s → WRITE_IMM shows writenum=0, vsel=01, write=1, sximm8=0x0007; w=1 three cycles later. Repeat with 0xD1FE → sximm8=0xFFFE, writenum=1.
- Load 0xA148 (ADD R2,R1,R0,LSL#1) → GET_A: readnum=1, loada. GET_B: readnum=0, loadb. ALU: shift=01, ALUop=00, loadc. WRITE_REG: writenum=2, vsel=11, write. w returns after 5 cycles.
- Load 0xA900 (CMP R1,R0) → ALU state: loads=1, ALUop=01, loadc=0; write never asserted; w after 4 cycles.
- Load 0xB860 (MVN R3,R0) → GET_A skipped, ALUop=11, writenum=3 write-back; w after 4 cycles. load=1 pulsed mid-instruction leaves IR unchanged.
- Load 0xE000 and pulse s → err=1 after DECODE, no enable asserted, w=1 after 2 cycles. A following legal instruction clears err.
- Drive reset_n low during GET_B of an ADD → all enables 0 and w=1 with no clock edge; IR=0; no write occurs after release.
